// File: rtl/mc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_pkg                                                              |
// | State, opcode, funct and control encodings for mc_control_fsm.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;

   localparam logic [5:0] c_fn_add = 6'b100000;
   localparam logic [5:0] c_fn_sub = 6'b100010;
   localparam logic [5:0] c_fn_and = 6'b100100;
   localparam logic [5:0] c_fn_or  = 6'b100101;
   localparam logic [5:0] c_fn_slt = 6'b101010;

   localparam logic [2:0] c_alu_add = 3'b010;
   localparam logic [2:0] c_alu_sub = 3'b110;
   localparam logic [2:0] c_alu_and = 3'b000;
   localparam logic [2:0] c_alu_or  = 3'b001;
   localparam logic [2:0] c_alu_slt = 3'b111;

   localparam logic [1:0] c_srcb_regb  = 2'b00;
   localparam logic [1:0] c_srcb_four  = 2'b01;
   localparam logic [1:0] c_srcb_imm   = 2'b10;
   localparam logic [1:0] c_srcb_immsh = 2'b11;

   localparam logic [1:0] c_pcsrc_alu    = 2'b00;
   localparam logic [1:0] c_pcsrc_aluout = 2'b01;
   localparam logic [1:0] c_pcsrc_jump   = 2'b10;

   localparam logic [1:0] c_aluop_add   = 2'b00;
   localparam logic [1:0] c_aluop_sub   = 2'b01;
   localparam logic [1:0] c_aluop_funct = 2'b10;

   typedef struct packed {
      logic       fetch;
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_wr;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [1:0] aluop;
   } ctrl_t;

   // Moore decode; fetch/branch are later qualified by mem_ready and zero.
   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.fetch     = 1'b1;
            c.mem_rd    = 1'b1;
            c.alu_src_b = c_srcb_four;
            c.pc_src    = c_pcsrc_alu;
            c.aluop     = c_aluop_add;
         end
         S_DECODE:   c.alu_src_b = c_srcb_immsh;
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = c_srcb_imm;
         end
         S_MEMRD: begin
            c.iord   = 1'b1;
            c.mem_rd = 1'b1;
         end
         S_MEMWB: begin
            c.reg_wr     = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            c.iord   = 1'b1;
            c.mem_wr = 1'b1;
         end
         S_EXECUTE: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = c_srcb_regb;
            c.aluop     = c_aluop_funct;
         end
         S_ALUWB: begin
            c.reg_wr  = 1'b1;
            c.reg_dst = 1'b1;
         end
         S_BRANCH: begin
            c.branch    = 1'b1;
            c.alu_src_a = 1'b1;
            c.aluop     = c_aluop_sub;
            c.pc_src    = c_pcsrc_aluout;
         end
         S_ADDIEXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = c_srcb_imm;
         end
         S_ADDIWB:   c.reg_wr = 1'b1;
         S_JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = c_pcsrc_jump;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_alu_dec                                                          |
// | Combinational ALU decoder: (aluop, funct) -> alu_ctrl.              |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mc_alu_dec
   import mc_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = c_alu_add;
      case (aluop)
         c_aluop_sub: alu_ctrl = c_alu_sub;
         c_aluop_funct: begin
            case (funct)
               c_fn_add: alu_ctrl = c_alu_add;
               c_fn_sub: alu_ctrl = c_alu_sub;
               c_fn_and: alu_ctrl = c_alu_and;
               c_fn_or:  alu_ctrl = c_alu_or;
               c_fn_slt: alu_ctrl = c_alu_slt;
               default:  alu_ctrl = c_alu_add;
            endcase
         end
         default: alu_ctrl = c_alu_add;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_control_fsm                                                      |
// | Multi-cycle MIPS control FSM. Define MC_BNE_EN to add bne support.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mc_control_fsm
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       ir_wr,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_wr,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_ctrl,
   output logic [3:0] state_o
);

   state_t r_state;
   state_t w_next;
   ctrl_t  r_ctrl;
   logic   w_taken;
   logic   w_fetch_go;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               c_op_lw, c_op_sw: w_next = S_MEMADR;
               c_op_rtype:       w_next = S_EXECUTE;
               c_op_beq:         w_next = S_BRANCH;
`ifdef MC_BNE_EN
               c_op_bne:         w_next = S_BRANCH;
`endif
               c_op_addi:        w_next = S_ADDIEXEC;
               c_op_j:           w_next = S_JUMP;
               default:          w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (op == c_op_lw) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    w_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWR:    w_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE:  w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_ADDIEXEC: w_next = S_ADDIWB;
         S_ADDIWB:   w_next = S_FETCH;
         S_JUMP:     w_next = S_FETCH;
         default:    w_next = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state so they track r_state exactly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_FETCH;
         r_ctrl  <= decode_state(S_FETCH);
      end else begin
         r_state <= w_next;
         r_ctrl  <= decode_state(w_next);
      end
   end

`ifdef MC_BNE_EN
   logic r_is_bne;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_is_bne <= 1'b0;
      end else if (r_state == S_DECODE) begin
         r_is_bne <= (op == c_op_bne);
      end
   end

   assign w_taken = r_is_bne ? ~zero : zero;
`else
   assign w_taken = zero;
`endif

   // rst gates the fetch strobes so a held reset never writes IR or PC.
   assign w_fetch_go = r_ctrl.fetch & mem_ready & rst;

   assign pc_en      = w_fetch_go | r_ctrl.pc_write | (r_ctrl.branch & w_taken);
   assign ir_wr      = w_fetch_go;
   assign iord       = r_ctrl.iord;
   assign mem_rd     = r_ctrl.mem_rd;
   assign mem_wr     = r_ctrl.mem_wr;
   assign reg_dst    = r_ctrl.reg_dst;
   assign mem_to_reg = r_ctrl.mem_to_reg;
   assign reg_wr     = r_ctrl.reg_wr;
   assign alu_src_a  = r_ctrl.alu_src_a;
   assign alu_src_b  = r_ctrl.alu_src_b;
   assign pc_src     = r_ctrl.pc_src;
   assign state_o    = r_state;

   mc_alu_dec u_alu_dec (
      .aluop    (r_ctrl.aluop),
      .funct    (funct),
      .alu_ctrl (alu_ctrl)
   );

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mc_control_fsm                                                   |
// | Directed self-checking bench for mc_control_fsm.                    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_mc_control_fsm;

   logic       clk;
   logic       rst;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr, alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic [2:0] alu_ctrl;
   logic [3:0] state_o;
   logic [19:0] w_outs;

   int n_pass;
   int n_total;

   // {pc_en,iord,mem_rd,mem_wr,ir_wr,reg_dst,mem_to_reg,reg_wr,alu_src_a}, srcb, pcsrc, alu, state
   localparam logic [19:0] c_fetch_go   = {9'b101010000, 2'b01, 2'b00, 3'b010, 4'd0};
   localparam logic [19:0] c_fetch_wait = {9'b001000000, 2'b01, 2'b00, 3'b010, 4'd0};
   localparam logic [19:0] c_decode     = {9'b000000000, 2'b11, 2'b00, 3'b010, 4'd1};
   localparam logic [19:0] c_memadr     = {9'b000000001, 2'b10, 2'b00, 3'b010, 4'd2};
   localparam logic [19:0] c_memrd      = {9'b011000000, 2'b00, 2'b00, 3'b010, 4'd3};
   localparam logic [19:0] c_memwb      = {9'b000000110, 2'b00, 2'b00, 3'b010, 4'd4};
   localparam logic [19:0] c_memwr      = {9'b010100000, 2'b00, 2'b00, 3'b010, 4'd5};
   localparam logic [19:0] c_aluwb      = {9'b000001010, 2'b00, 2'b00, 3'b010, 4'd7};
   localparam logic [19:0] c_br_taken   = {9'b100000001, 2'b00, 2'b01, 3'b110, 4'd8};
   localparam logic [19:0] c_br_not     = {9'b000000001, 2'b00, 2'b01, 3'b110, 4'd8};
   localparam logic [19:0] c_addiex     = {9'b000000001, 2'b10, 2'b00, 3'b010, 4'd9};
   localparam logic [19:0] c_addiwb     = {9'b000000010, 2'b00, 2'b00, 3'b010, 4'd10};
   localparam logic [19:0] c_jump       = {9'b100000000, 2'b00, 2'b10, 3'b010, 4'd11};

   assign w_outs = {pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
                    alu_src_a, alu_src_b, pc_src, alu_ctrl, state_o};

   mc_control_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .ir_wr      (ir_wr),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_wr     (reg_wr),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_ctrl   (alu_ctrl),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b0; mem_ready = 1'b1;
      #1;
      n_total++;
      if (w_outs !== c_fetch_wait)
         $display("FAIL reset_outputs: got %b expected %b", w_outs, c_fetch_wait);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (w_outs !== c_fetch_wait)
         $display("FAIL reset_held_clock: got %b expected %b", w_outs, c_fetch_wait);
      else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_lw();
      logic [19:0] want [5];
      want = '{c_fetch_go, c_decode, c_memadr, c_memrd, c_memwb};
      op = 6'b100011; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_total++;
         if (w_outs !== want[i])
            $display("FAIL lw cycle%0d: got %b expected %b", i, w_outs, want[i]);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_lw_wait();
      logic [19:0] want [6];
      logic        rdy  [6];
      want = '{c_fetch_go, c_decode, c_memadr, c_memrd, c_memrd, c_memwb};
      rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      op = 6'b100011;
      for (int i = 0; i < 6; i++) begin
         mem_ready = rdy[i];
         #1;
         n_total++;
         if (w_outs !== want[i])
            $display("FAIL lw_wait cycle%0d: got %b expected %b", i, w_outs, want[i]);
         else n_pass++;
         @(negedge clk);
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_rtype();
      logic [5:0]  fn  [5];
      logic [2:0]  alu [5];
      logic [19:0] want [4];
      fn  = '{6'b100010, 6'b101010, 6'b100100, 6'b100101, 6'b111111};
      alu = '{3'b110,    3'b111,    3'b000,    3'b001,    3'b010};
      op = 6'b000000; mem_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         funct = fn[j];
         want = '{c_fetch_go, c_decode, {9'b000000001, 2'b00, 2'b00, alu[j], 4'd6}, c_aluwb};
         for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (w_outs !== want[i])
               $display("FAIL rtype funct=%b cycle%0d: got %b expected %b", fn[j], i, w_outs, want[i]);
            else n_pass++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_branch(input logic [5:0] opc, input logic z, input logic [19:0] br_want,
                              input logic to_branch);
      logic [19:0] want [3];
      int          n;
      want = '{c_fetch_go, c_decode, br_want};
      n    = to_branch ? 3 : 2;
      op = opc; zero = z; mem_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         n_total++;
         if (w_outs !== want[i])
            $display("FAIL branch op=%b zero=%b cycle%0d: got %b expected %b", opc, z, i, w_outs, want[i]);
         else n_pass++;
         @(negedge clk);
      end
      zero = 1'b0;
   endtask

   task automatic test_addi();
      logic [19:0] want [4];
      want = '{c_fetch_go, c_decode, c_addiex, c_addiwb};
      op = 6'b001000; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_total++;
         if (w_outs !== want[i])
            $display("FAIL addi cycle%0d: got %b expected %b", i, w_outs, want[i]);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_fetch_wait();
      logic [19:0] want [6];
      logic        rdy  [6];
      want = '{c_fetch_wait, c_fetch_wait, c_fetch_wait, c_fetch_go, c_decode, c_jump};
      rdy  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      op = 6'b000010;
      for (int i = 0; i < 6; i++) begin
         mem_ready = rdy[i];
         #1;
         n_total++;
         if (w_outs !== want[i])
            $display("FAIL fetch_wait/jump cycle%0d: got %b expected %b", i, w_outs, want[i]);
         else n_pass++;
         @(negedge clk);
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_sw_reset();
      logic [19:0] want [5];
      logic        rdy  [5];
      want = '{c_fetch_go, c_decode, c_memadr, c_memwr, c_memwr};
      rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      op = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i];
         #1;
         n_total++;
         if (w_outs !== want[i])
            $display("FAIL sw_wait cycle%0d: got %b expected %b", i, w_outs, want[i]);
         else n_pass++;
         if (i < 4) @(negedge clk);
      end
      #1 rst = 1'b0;
      #1;
      n_total++;
      if (mem_wr !== 1'b0)
         $display("FAIL sw_reset mem_wr: got %b expected 0", mem_wr);
      else n_pass++;
      n_total++;
      if (w_outs !== c_fetch_wait)
         $display("FAIL sw_reset outputs: got %b expected %b", w_outs, c_fetch_wait);
      else n_pass++;
      mem_ready = 1'b1;
      #1;
      n_total++;
      if (w_outs !== c_fetch_wait)
         $display("FAIL sw_reset ready_masked: got %b expected %b", w_outs, c_fetch_wait);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      want = '{c_fetch_go, c_decode, c_memadr, c_memwr, c_fetch_go};
      for (int i = 0; i < 4; i++) begin
         #1;
         n_total++;
         if (w_outs !== want[i])
            $display("FAIL sw_restart cycle%0d: got %b expected %b", i, w_outs, want[i]);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_final_fetch();
      mem_ready = 1'b0;
      #1;
      n_total++;
      if (w_outs !== c_fetch_wait)
         $display("FAIL final_fetch: got %b expected %b", w_outs, c_fetch_wait);
      else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_lw();
      test_lw_wait();
      test_rtype();
      test_branch(6'b000100, 1'b1, c_br_taken, 1'b1);
      test_branch(6'b000100, 1'b0, c_br_not, 1'b1);
      test_addi();
      test_fetch_wait();
      test_sw_reset();
`ifdef MC_BNE_EN
      test_branch(6'b000101, 1'b0, c_br_taken, 1'b1);
      test_branch(6'b000101, 1'b1, c_br_not, 1'b1);
`else
      test_branch(6'b000101, 1'b0, c_br_taken, 1'b0);
`endif
      test_branch(6'b111111, 1'b0, c_br_not, 1'b0);
      test_final_fetch();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
